// File: rtl/dm_store_buffer.sv
// dm_store_buffer: MEM-stage data memory, store FIFO draining to a word array.
// Optional coalescing of stores into pending entries: define DM_COALESCE_EN.
module dm_store_buffer #(
  parameter int DEPTH     = 4,
  parameter int WR_CYC    = 2,
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        DM_en,
  input  logic        DM_write,
  input  logic [31:0] DM_address,
  input  logic [31:0] DM_in,
  output logic [31:0] DM_out,
  output logic        DM_stall,
  output logic        DM_idle
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = (WR_CYC > 1) ? $clog2(WR_CYC) : 1;
  localparam logic [PW:0]   FULL = (PW+1)'(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(WR_CYC - 1);

  typedef enum logic {S_IDLE, S_WRITE} state_e;

  logic [DEPTH-1:0] valid_q;
  logic [AW-1:0]    idx_q  [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [PW:0]      count_q, count_d;
  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [31:0]      mem_q [MEM_WORDS];

  logic [AW-1:0] idx;
  logic          load, store, pop, push, hit, fwd;
  logic [31:0]   fwd_data;
  logic          unused_addr;

  assign idx = DM_address[AW+1:2];
  assign unused_addr = ^{DM_address[31:AW+2], DM_address[1:0]};

  // Youngest pending entry with a matching index wins the forward.
  always_comb begin
    logic [PW-1:0] p;
    p = '0;
    fwd = 1'b0;
    fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      p = head_q + PW'(k);
      if (valid_q[p] && idx_q[p] == idx) begin
        fwd = 1'b1;
        fwd_data = data_q[p];
      end
    end
  end

`ifdef DM_COALESCE_EN
  logic [PW-1:0] hit_pos;

  // Merge into a pending entry, never into the head being written.
  always_comb begin
    logic [PW-1:0] p;
    p = '0;
    hit = 1'b0;
    hit_pos = '0;
    for (int k = 0; k < DEPTH; k++) begin
      p = head_q + PW'(k);
      if (store && valid_q[p] && idx_q[p] == idx &&
          !(state_q == S_WRITE && p == head_q)) begin
        hit = 1'b1;
        hit_pos = p;
      end
    end
  end
`else
  assign hit = 1'b0;
`endif

  // Handshake, occupancy and drain FSM next state.
  always_comb begin
    load = DM_en & ~DM_write;
    store = DM_en & DM_write;
    pop = (state_q == S_WRITE) && (cnt_q == LAST);
    DM_stall = store && (count_q == FULL) && !pop && !hit && !rst;
    push = store && !hit && !DM_stall;
    count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
    head_d = pop ? head_q + 1'b1 : head_q;
    tail_d = push ? tail_q + 1'b1 : tail_q;
    state_d = state_q;
    cnt_d = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          state_d = S_WRITE;
          cnt_d = '0;
        end
      end
      S_WRITE: begin
        if (pop) begin
          cnt_d = '0;
          state_d = (count_d != '0) ? S_WRITE : S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  // Loads see the buffer only outside reset; otherwise the array.
  always_comb begin
    DM_out = '0;
    if (load) begin
      DM_out = (fwd && !rst) ? fwd_data : mem_q[idx];
    end
    DM_idle = rst | ((count_q == '0) && (state_q == S_IDLE));
  end

  // FIFO pointers, entries and drain FSM state.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      if (pop) begin
        valid_q[head_q] <= 1'b0;
      end
      if (push) begin
        valid_q[tail_q] <= 1'b1;
        idx_q[tail_q]   <= idx;
        data_q[tail_q]  <= DM_in;
      end
`ifdef DM_COALESCE_EN
      if (hit) begin
        data_q[hit_pos] <= DM_in;
      end
`endif
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Array write on the commit edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && pop) begin
      mem_q[idx_q[head_q]] <= data_q[head_q];
    end
  end

endmodule

// File: tb/tb_dm_store_buffer.sv
// tb_dm_store_buffer: scoreboard bench for dm_store_buffer.
// Architectural word model predicts every load result.
module tb_dm_store_buffer;
  logic        clk = 1'b0;
  logic        rst;
  logic        DM_en;
  logic        DM_write;
  logic [31:0] DM_address;
  logic [31:0] DM_in;
  logic [31:0] DM_out;
  logic        DM_stall;
  logic        DM_idle;

  always #5 clk = ~clk;

  dm_store_buffer #(
    .DEPTH(4),
    .WR_CYC(2),
    .MEM_WORDS(1024)
  ) dut (
    .clk(clk),
    .rst(rst),
    .DM_en(DM_en),
    .DM_write(DM_write),
    .DM_address(DM_address),
    .DM_in(DM_in),
    .DM_out(DM_out),
    .DM_stall(DM_stall),
    .DM_idle(DM_idle)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model[int];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drv_idle();
    DM_en = 1'b0;
    DM_write = 1'b0;
    DM_address = '0;
    DM_in = '0;
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'(a[11:2]);
  endfunction

  task automatic st(input string tag, input logic [31:0] a,
                    input logic [31:0] d);
    DM_en = 1'b1;
    DM_write = 1'b1;
    DM_address = a;
    DM_in = d;
    mid();
    chk({tag, "_stall"}, 32'(DM_stall), 32'd0);
    step();
    model[widx(a)] = d;
    drv_idle();
  endtask

  task automatic ld(input string tag, input logic [31:0] a);
    DM_en = 1'b1;
    DM_write = 1'b0;
    DM_address = a;
    DM_in = '0;
    exp_q.push_back(model[widx(a)]);
    mid();
    chk(tag, DM_out, exp_q.pop_front());
    step();
    drv_idle();
  endtask

  task automatic idle_cyc(input string tag, input logic e);
    drv_idle();
    mid();
    chk(tag, 32'(DM_idle), 32'(e));
    step();
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    drv_idle();
    mid();
    while (!DM_idle && n < 50) begin
      step();
      mid();
      n++;
    end
    chk(tag, 32'(DM_idle), 32'd1);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drv_idle();
    mid();
    chk("rst_idle", 32'(DM_idle), 32'd1);
    chk("rst_stall", 32'(DM_stall), 32'd0);
    step();
    step();
    rst = 1'b0;
    mid();
    chk("post_rst_idle", 32'(DM_idle), 32'd1);
    step();

    st("t1_st", 32'h100, 32'hDEADBEEF);
    ld("t1_fwd0", 32'h100);
    ld("t1_fwd1", 32'h100);
    idle_cyc("t1_busy", 1'b0);
    idle_cyc("t1_idle", 1'b1);
    ld("t1_array", 32'h100);

    for (int i = 0; i < 6; i++) begin
      st("t2_st", 32'h500 + 32'(4 * i), 32'h5000_0000 + 32'(i));
    end
    DM_en = 1'b1;
    DM_write = 1'b1;
    DM_address = 32'h518;
    DM_in = 32'h5000_0006;
    mid();
    chk("t2_full_stall", 32'(DM_stall), 32'd1);
    step();
    mid();
    chk("t2_pop_accept", 32'(DM_stall), 32'd0);
    step();
    model[widx(32'h518)] = 32'h5000_0006;
    drv_idle();
    for (int k = 7; k <= 15; k++) begin
      idle_cyc("t2_drain", k >= 15);
    end
    for (int i = 0; i < 7; i++) begin
      ld("t2_array", 32'h500 + 32'(4 * i));
    end

    st("t3_a", 32'h200, 32'd1);
    st("t3_b", 32'h204, 32'd2);
    st("t3_c", 32'h204, 32'd3);
    ld("t3_fwd", 32'h204);
    for (int k = 3; k <= 7; k++) begin
`ifdef DM_COALESCE_EN
      idle_cyc("t3_drain", k >= 5);
`else
      idle_cyc("t3_drain", k >= 7);
`endif
    end
    ld("t3_arr204", 32'h204);
    ld("t3_arr200", 32'h200);

    st("t4_a", 32'h300, 32'hA);
    idle_cyc("t4_busy", 1'b0);
    st("t4_b", 32'h300, 32'hB);
    ld("t4_fwd", 32'h300);
    for (int k = 3; k <= 5; k++) begin
      idle_cyc("t4_drain", k >= 5);
    end
    ld("t4_array", 32'h300);

    st("t5_st", 32'h4, 32'h12345678);
    wait_idle("t5_drain");
    ld("t5_wrap", 32'h1004);
    ld("t5_lowbits", 32'h1007);
    DM_en = 1'b0;
    DM_write = 1'b0;
    DM_address = 32'h1004;
    exp_q.push_back(32'd0);
    mid();
    chk("t5_no_en", DM_out, exp_q.pop_front());
    step();

    st("t6_p0", 32'h400, 32'h11);
    st("t6_p1", 32'h404, 32'h22);
    st("t6_p2", 32'h408, 32'h33);
    wait_idle("t6_pre");
    st("t6_a", 32'h400, 32'hA1);
    st("t6_b", 32'h404, 32'hA2);
    st("t6_c", 32'h408, 32'hA3);
    idle_cyc("t6_busy", 1'b0);
    rst = 1'b1;
    DM_en = 1'b1;
    DM_write = 1'b0;
    DM_address = 32'h404;
    exp_q.push_back(32'h22);
    mid();
    chk("t6_rst_load", DM_out, exp_q.pop_front());
    chk("t6_rst_idle", 32'(DM_idle), 32'd1);
    chk("t6_rst_stall", 32'(DM_stall), 32'd0);
    step();
    rst = 1'b0;
    drv_idle();
    mid();
    chk("t6_post_idle", 32'(DM_idle), 32'd1);
    chk("t6_post_stall", 32'(DM_stall), 32'd0);
    step();
    model[widx(32'h400)] = 32'hA1;
    model[widx(32'h404)] = 32'h22;
    model[widx(32'h408)] = 32'h33;
    ld("t6_arr400", 32'h400);
    ld("t6_arr404", 32'h404);
    ld("t6_arr408", 32'h408);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
